// File: rtl/mlp_pkg.sv
// Shared widths, scaling constants and FSM states for the MLP datapath.
// Build option: MLP_RELU_EN clamps negative results to zero.
package mlp_pkg;

  localparam int NEURON_W   = 16;
  localparam int WEIGHT_W   = 8;
  localparam int BIAS_W     = 8;
  localparam int ADDR_W     = 12;
  localparam int ACC_W      = 36;
  localparam int PROD_W     = NEURON_W + WEIGHT_W;
  localparam int BIAS_SHIFT = 8;
  localparam int OUT_SHIFT  = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/mult_acc_3_sat_relu_3.sv
// Q?.15 accumulator to Q8.8 output: shift, saturate, optional ReLU.
// Build option: MLP_RELU_EN forces negative results to 0x0000.
module sat_relu_3
  import mlp_pkg::*;
(
  input  logic [ACC_W-1:0]    acc_i,
  output logic [NEURON_W-1:0] val_o
);

  logic signed [ACC_W-1:0] shifted;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic [NEURON_W-1:0]     sat;

  assign shifted = $signed(acc_i) >>> OUT_SHIFT;

  // Bits above the 16-bit sign position must all match the sign bit.
  assign pos_ovf = ~shifted[ACC_W-1] &
                   (|shifted[ACC_W-2:NEURON_W-1]);
  assign neg_ovf = shifted[ACC_W-1] &
                   ~(&shifted[ACC_W-2:NEURON_W-1]);

  always_comb begin
    sat = shifted[NEURON_W-1:0];
    if (pos_ovf) sat = {1'b0, {(NEURON_W-1){1'b1}}};
    if (neg_ovf) sat = {1'b1, {(NEURON_W-1){1'b0}}};
  end

`ifdef MLP_RELU_EN
  assign val_o = sat[NEURON_W-1] ? '0 : sat;
`else
  assign val_o = sat;
`endif

endmodule

// File: rtl/mult_acc_3.sv
// Multiply-accumulate neuron stage: bias + sum(act*weight), Q8.8 out.
// Build option: MLP_RELU_EN (see sat_relu_3).
module mult_acc_3
  import mlp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                done_3,
  input  logic [NEURON_W-1:0] neuron_val_3,
  input  logic [WEIGHT_W-1:0] weight_val_3,
  input  logic [BIAS_W-1:0]   bias_val_3,
  input  logic                reset_mult_acc_3,
  input  logic [ADDR_W-1:0]   out_neuron_addr_3,
  input  logic                write_neuron_3,
  output logic [NEURON_W-1:0] neuron_val_4,
  output logic [ADDR_W-1:0]   out_neuron_addr_4,
  output logic                write_neuron_4,
  output logic                done_4
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [NEURON_W-1:0] val_q, val_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         bias_term;
  logic [NEURON_W-1:0]      sat_val;
  logic                     live;
  logic                     fire;

  assign prod      = PROD_W'($signed(neuron_val_3)) *
                     PROD_W'($signed(weight_val_3));
  assign prod_ext  = ACC_W'(prod);
  assign bias_term = ACC_W'($signed(bias_val_3)) << BIAS_SHIFT;

  assign live = (state_q != DONE);
  assign fire = live & (reset_mult_acc_3 | (state_q == ACCUM));

  sat_relu_3 u_sat (
    .acc_i (acc_d),
    .val_o (sat_val)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    val_d   = val_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    done_d  = done_q;
    if (live) begin
      // A new first term drops any partial sum.
      if (reset_mult_acc_3)
        acc_d = bias_term + prod_ext;
      else if (state_q == ACCUM)
        acc_d = acc_q + prod_ext;
      if (write_neuron_3 && fire) begin
        wr_d    = 1'b1;
        val_d   = sat_val;
        addr_d  = out_neuron_addr_3;
        state_d = IDLE;
      end else if (reset_mult_acc_3) begin
        state_d = ACCUM;
      end
      if (done_3) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      val_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign neuron_val_4      = val_q;
  assign out_neuron_addr_4 = addr_q;
  assign write_neuron_4    = wr_q;
  assign done_4            = done_q;

endmodule

// File: tb/tb_mult_acc_3.sv
// Random + directed bench for mult_acc_3 against a sum-of-terms model.
// Build option: MLP_RELU_EN selects the ReLU expectations.
module tb_mult_acc_3;

  logic               clk = 1'b0;
  logic               reset;
  logic               done3;
  logic signed [15:0] n3;
  logic signed [7:0]  w3;
  logic signed [7:0]  b3;
  logic               racc;
  logic [11:0]        addr3;
  logic               we;
  logic [15:0]        val4;
  logic [11:0]        addr4;
  logic               wr4;
  logic               done4;

  int checks = 0;
  int errors = 0;

  bit     m_open;
  bit     m_done;
  longint m_sum;
  bit     e_wr;
  bit     e_done;
  longint e_val;
  longint e_addr;

  always #5 clk = ~clk;

  mult_acc_3 dut (
    .clk               (clk),
    .reset             (reset),
    .done_3            (done3),
    .neuron_val_3      (n3),
    .weight_val_3      (w3),
    .bias_val_3        (b3),
    .reset_mult_acc_3  (racc),
    .out_neuron_addr_3 (addr3),
    .write_neuron_3    (we),
    .neuron_val_4      (val4),
    .out_neuron_addr_4 (addr4),
    .write_neuron_4    (wr4),
    .done_4            (done4)
  );

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Floor-divide by 128, clamp to int16, optional ReLU.
  function automatic longint conv(longint s);
    longint q;
    q = s / 128;
    if (s < 0 && (s % 128) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef MLP_RELU_EN
    if (q < 0) q = 0;
`endif
    return q & 64'hFFFF;
  endfunction

  task automatic model_reset();
    m_open = 0;
    m_done = 0;
    m_sum  = 0;
    e_wr   = 0;
    e_done = 0;
    e_val  = 0;
    e_addr = 0;
  endtask

  task automatic model_cycle();
    longint p;
    bit     fire;
    e_wr = 0;
    if (m_done) return;
    p    = longint'(n3) * longint'(w3);
    fire = racc || m_open;
    if (racc) begin
      m_sum  = longint'(b3) * 256 + p;
      m_open = 1;
    end else if (m_open) begin
      m_sum = m_sum + p;
    end
    if (we && fire) begin
      e_wr   = 1;
      e_val  = conv(m_sum);
      e_addr = addr3;
      m_open = 0;
    end
    if (done3) begin
      m_done = 1;
      e_done = 1;
    end
  endtask

  task automatic drive(input logic [15:0] n, input logic [7:0] w,
                       input logic [7:0] b, input logic ra,
                       input logic wn, input logic [11:0] a,
                       input logic d);
    n3    = n;
    w3    = w;
    b3    = b;
    racc  = ra;
    we    = wn;
    addr3 = a;
    done3 = d;
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".wr"}, longint'(wr4), longint'(e_wr));
    chk({tag, ".val"}, longint'(val4), e_val);
    chk({tag, ".addr"}, longint'(addr4), e_addr);
    chk({tag, ".done"}, longint'(done4), longint'(e_done));
  endtask

  task automatic step(string tag);
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b1;
    model_reset();
    #1 check_outs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp37;
    logic [15:0] exp38n;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("rst");
    reset = 1'b0;

    // Three-term neuron with bias
    drive(16'h0100, 8'h40, 8'h20, 1, 0, 12'h000, 0);
    step("t36a");
    drive(16'h0100, 8'h40, 8'h00, 0, 0, 12'h000, 0);
    step("t36b");
    drive(16'h0100, 8'h40, 8'h00, 0, 1, 12'h005, 0);
    step("t36c");
    chk("r036.val", longint'(val4), 64'h01C0);
    chk("r036.wr", longint'(wr4), 1);

    // Hold after strobe
    drive(16'h1234, 8'h11, 8'h00, 0, 0, 12'h777, 0);
    step("hold");

    // Single-term negative neuron
    drive(16'h0100, 8'h80, 8'h00, 1, 1, 12'h00A, 0);
    step("t37");
`ifdef MLP_RELU_EN
    exp37 = 16'h0000;
`else
    exp37 = 16'hFF00;
`endif
    chk("r037.val", longint'(val4), longint'(exp37));

    // Positive saturation
    drive(16'h7FFF, 8'h7F, 8'h7F, 1, 0, 12'h010, 0);
    step("t38a");
    repeat (2) begin
      drive(16'h7FFF, 8'h7F, 8'h00, 0, 0, 12'h010, 0);
      step("t38b");
    end
    drive(16'h7FFF, 8'h7F, 8'h00, 0, 1, 12'h011, 0);
    step("t38c");
    chk("r038.pos", longint'(val4), 64'h7FFF);

    // Negative saturation
    drive(16'h8000, 8'h7F, 8'h7F, 1, 0, 12'h020, 0);
    step("t38d");
    repeat (2) begin
      drive(16'h8000, 8'h7F, 8'h00, 0, 0, 12'h020, 0);
      step("t38e");
    end
    drive(16'h8000, 8'h7F, 8'h00, 0, 1, 12'h021, 0);
    step("t38f");
`ifdef MLP_RELU_EN
    exp38n = 16'h0000;
`else
    exp38n = 16'h8000;
`endif
    chk("r038.neg", longint'(val4), longint'(exp38n));

    // Write in IDLE is ignored
    drive(16'h0100, 8'h40, 8'h00, 0, 1, 12'h123, 0);
    step("idle_wr");

    // Reset mid-neuron, then a fresh single term
    drive(16'h0500, 8'h70, 8'h30, 1, 0, 12'h000, 0);
    step("t39a");
    drive(16'h0500, 8'h70, 8'h00, 0, 0, 12'h000, 0);
    step("t39b");
    drive(0, 0, 0, 0, 0, 0, 0);
    async_reset("t39rst");
    drive(16'h0100, 8'h40, 8'h00, 1, 1, 12'h007, 0);
    step("t39c");
    chk("r039.val", longint'(val4), 64'h0080);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            12'($urandom), 0);
      step("rnd");
    end

    // done_3 with a pending write
    drive(16'h0100, 8'h40, 8'h10, 1, 0, 12'h000, 0);
    step("t40a");
    drive(16'h0200, 8'h20, 8'h00, 0, 1, 12'h0AB, 1);
    step("t40b");
    chk("r040.wr", longint'(wr4), 1);
    chk("r040.done", longint'(done4), 1);
    for (int i = 0; i < 20; i++) begin
      drive(16'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 12'($urandom),
            1'($urandom));
      step("t40idle");
    end
    chk("r040.sticky", longint'(done4), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    async_reset("t40rst");
    step("post");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_acc_3.md
MULT_ACC_3 -- requirements
Module: mult_acc_3

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 done_3  input  1  upstream layer complete.
REQ-005 neuron_val_3  input  16  signed Q8.8 input activation.
REQ-006 weight_val_3  input  8  signed Q1.7 weight.
REQ-007 bias_val_3  input  8  signed Q1.7 bias; sampled only when reset_mult_acc_3=1.
REQ-008 reset_mult_acc_3  input  1  first term of a new output neuron.
REQ-009 out_neuron_addr_3  input  12  destination address; sampled when write_neuron_3=1.
REQ-010 write_neuron_3  input  1  last term of the current neuron.
REQ-011 neuron_val_4  output  16  signed Q8.8 result.
REQ-012 out_neuron_addr_4  output  12  result address.
REQ-013 write_neuron_4  output  1  one-cycle write strobe.
REQ-014 done_4  output  1  sticky layer-complete flag.

Function
REQ-015 Product SHALL be a full-precision signed 24-bit value, neuron_val_3*weight_val_3, with 15 fraction bits.
REQ-016 The accumulator SHALL be 36-bit signed, so no overflow is possible for up to 4096 terms.
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 IDLE: terms SHALL be ignored and the accumulator held.
REQ-019 IDLE to ACCUM SHALL occur on reset_mult_acc_3=1.
REQ-020 reset_mult_acc_3=1, in IDLE or ACCUM, SHALL load acc <= (sext(bias)<<8) + product; any partial sum SHALL be discarded.
REQ-021 ACCUM with reset_mult_acc_3=0 SHALL update acc <= acc + product.
REQ-022 write_neuron_3=1 at cycle N (in ACCUM, or together with reset_mult_acc_3) SHALL:
- assert write_neuron_4 for exactly cycle N+1;
- drive neuron_val_4 as the final sum including term N;
- drive out_neuron_addr_4 as the address sampled at cycle N;
- return the FSM to IDLE.
REQ-023 reset_mult_acc_3 and write_neuron_3 together SHALL produce a single-term neuron.
REQ-024 write_neuron_3 in IDLE without reset_mult_acc_3 SHALL be ignored: no write and no state change.
REQ-025 Output conversion SHALL be in order:
- arithmetic shift right 7 (truncation toward minus infinity);
- saturation to signed 16-bit, range 0x8000..0x7FFF;
- optional ReLU per REQ-033.
REQ-026 neuron_val_4 and out_neuron_addr_4 SHALL hold their last values when write_neuron_4=0.
REQ-027 done_3=1 at cycle N SHALL set done_4 at N+1 and move the FSM to DONE.
REQ-028 A write_neuron_3 coinciding with done_3 SHALL still be emitted at N+1.
REQ-029 DONE SHALL ignore all inputs until reset.

Reset
REQ-030 Reset SHALL asynchronously force the following, regardless of state or any in-flight neuron:
- FSM to IDLE;
- accumulator to 0;
- neuron_val_4=0, out_neuron_addr_4=0, write_neuron_4=0, done_4=0.
REQ-031 The first rising clk edge after reset deasserts SHALL behave as an IDLE cycle.

Configuration
REQ-032 The feature SHALL be controlled by the macro MLP_RELU_EN.
REQ-033 With MLP_RELU_EN defined, saturated results below 0 SHALL be output as 0x0000; without it, the signed saturated value SHALL pass unchanged.

Structure
REQ-034 Package mlp_pkg SHALL hold:
- widths NEURON_W=16, WEIGHT_W=8, BIAS_W=8, ADDR_W=12, ACC_W=36;
- constants BIAS_SHIFT=8 and OUT_SHIFT=7;
- the FSM state enum.
REQ-035 Shift, saturation and ReLU SHALL be one combinational sub-module, sat_relu_3, instantiated once.

Verification
REQ-036 Three terms of neuron 0x0100 and weight 0x40 with bias 0x20, write on the third term with addr 0x005 -> next cycle write_neuron_4=1, neuron_val_4=0x01C0, out_neuron_addr_4=0x005.
REQ-037 Single term with reset_mult_acc_3=1 and write_neuron_3=1, neuron 0x0100, weight 0x80, bias 0x00 -> 0x0000 with MLP_RELU_EN, 0xFF00 without.
REQ-038 Four terms of neuron 0x7FFF and weight 0x7F, bias 0x7F -> 0x7FFF (saturated); with neuron 0x8000 and MLP_RELU_EN undefined -> 0x8000.
REQ-039 Reset asserted mid-ACCUM after two terms, then a fresh neuron of one term 0x0100*0x40, bias 0 -> 0x0080, with no contribution from the discarded terms.
REQ-040 done_3 together with write_neuron_3 -> write_neuron_4 and done_4 both high next cycle; later reset_mult_acc_3/write_neuron_3 produce no writes; done_4 stays 1 until reset.
